// File: rtl/alu_issue_if.sv
// Signal bundle between ID/EX issue logic and its surroundings: IF/ID instruction,
// register-file reads, forwarding sources, and the EX-stage operand/control bundle.
interface alu_issue_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exm_wen;
  logic [4:0]  exm_wa;
  logic [31:0] exm_wd;
  logic        mwb_wen;
  logic [4:0]  mwb_wa;
  logic [31:0] mwb_wd;
  logic        flush;
  logic        stall_out;
  logic        out_valid;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [15:0] imm16;
  logic [3:0]  opt;
  logic        out_wen;
  logic [4:0]  out_wa;
  logic        out_memrd;
  logic        out_memwr;
  logic [31:0] out_pc;

  modport master (
    input  in_valid, in_instr, in_pc, rs_data, rt_data,
    input  exm_wen, exm_wa, exm_wd, mwb_wen, mwb_wa, mwb_wd, flush,
    output stall_out, out_valid, v1, v2, imm16, opt,
    output out_wen, out_wa, out_memrd, out_memwr, out_pc
  );

  modport slave (
    output in_valid, in_instr, in_pc, rs_data, rt_data,
    output exm_wen, exm_wa, exm_wd, mwb_wen, mwb_wa, mwb_wd, flush,
    input  stall_out, out_valid, v1, v2, imm16, opt,
    input  out_wen, out_wa, out_memrd, out_memwr, out_pc
  );
endinterface

// File: rtl/alu_issue.sv
// ID/EX issue stage: decode, operand select, hazard stall, registered ALU bundle.
// Define ALU_ISSUE_FORWARD_EN for forwarding muxes with load-use-only stalls.
module alu_issue (
  input logic  clk,
  input logic  reset_n,
  alu_issue_if.master bus
);

  logic [5:0]  op_p0;
  logic [5:0]  funct_p0;
  logic [4:0]  rs_a_p0;
  logic [4:0]  rt_a_p0;
  logic [4:0]  rd_a_p0;
  logic [3:0]  opt_p0;
  logic [4:0]  wa_p0;
  logic        wen_p0;
  logic        memrd_p0;
  logic        memwr_p0;
  logic        use_rs_p0;
  logic        use_rt_p0;
  logic [31:0] v1_p0;
  logic [31:0] v2_p0;
  logic        hazard_p0;

  logic        valid_p1;
  logic [31:0] v1_p1;
  logic [31:0] v2_p1;
  logic [15:0] imm_p1;
  logic [3:0]  opt_p1;
  logic        wen_p1;
  logic [4:0]  wa_p1;
  logic        memrd_p1;
  logic        memwr_p1;
  logic [31:0] pc_p1;

  assign op_p0    = bus.in_instr[31:26];
  assign funct_p0 = bus.in_instr[5:0];
  assign rs_a_p0  = bus.in_instr[25:21];
  assign rt_a_p0  = bus.in_instr[20:16];
  assign rd_a_p0  = bus.in_instr[15:11];

  always_comb begin
    opt_p0    = 4'd0;
    wa_p0     = 5'd0;
    wen_p0    = 1'b0;
    memrd_p0  = 1'b0;
    memwr_p0  = 1'b0;
    use_rs_p0 = 1'b0;
    use_rt_p0 = 1'b0;
    case (op_p0)
      6'h00: begin
        if (funct_p0 == 6'h21 || funct_p0 == 6'h23) begin
          opt_p0    = (funct_p0 == 6'h23) ? 4'd1 : 4'd0;
          wa_p0     = rd_a_p0;
          wen_p0    = 1'b1;
          use_rs_p0 = 1'b1;
          use_rt_p0 = 1'b1;
        end
      end
      6'h0c, 6'h0d: begin
        opt_p0    = (op_p0 == 6'h0d) ? 4'd3 : 4'd2;
        wa_p0     = rt_a_p0;
        wen_p0    = 1'b1;
        use_rs_p0 = 1'b1;
      end
      6'h23: begin
        opt_p0    = 4'd4;
        wa_p0     = rt_a_p0;
        wen_p0    = 1'b1;
        memrd_p0  = 1'b1;
        use_rs_p0 = 1'b1;
      end
      6'h2b: begin
        opt_p0    = 4'd4;
        memwr_p0  = 1'b1;
        use_rs_p0 = 1'b1;
        use_rt_p0 = 1'b1;
      end
      6'h0f: begin
        opt_p0 = 4'd5;
        wa_p0  = rt_a_p0;
        wen_p0 = 1'b1;
      end
      default: ;
    endcase
    // $0 is hardwired, so a write there is dropped at issue.
    if (wa_p0 == 5'd0) wen_p0 = 1'b0;
  end

`ifdef ALU_ISSUE_FORWARD_EN
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  a,
    input logic [31:0] rf,
    input logic        ew,
    input logic [4:0]  ea,
    input logic [31:0] ed,
    input logic        mw,
    input logic [4:0]  ma,
    input logic [31:0] md
  );
    if (a == 5'd0)            return 32'd0;
    else if (ew && ea == a)   return ed;
    else if (mw && ma == a)   return md;
    else                      return rf;
  endfunction

  assign v1_p0 = fwd_sel(rs_a_p0, bus.rs_data, bus.exm_wen, bus.exm_wa, bus.exm_wd,
                         bus.mwb_wen, bus.mwb_wa, bus.mwb_wd);
  assign v2_p0 = fwd_sel(rt_a_p0, bus.rt_data, bus.exm_wen, bus.exm_wa, bus.exm_wd,
                         bus.mwb_wen, bus.mwb_wa, bus.mwb_wd);

  // Only a load sitting in EX cannot be forwarded in time.
  assign hazard_p0 = bus.in_valid && valid_p1 && memrd_p1 && (wa_p1 != 5'd0) &&
                     ((use_rs_p0 && rs_a_p0 == wa_p1) || (use_rt_p0 && rt_a_p0 == wa_p1));
`else
  function automatic logic [31:0] rf_sel(input logic [4:0] a, input logic [31:0] rf);
    return (a == 5'd0) ? 32'd0 : rf;
  endfunction

  function automatic logic pending(
    input logic [4:0] a,
    input logic       xw,
    input logic [4:0] xa,
    input logic       ew,
    input logic [4:0] ea,
    input logic       mw,
    input logic [4:0] ma
  );
    return (a != 5'd0) && ((xw && xa == a) || (ew && ea == a) || (mw && ma == a));
  endfunction

  logic ex_w;
  logic unused_fwd;
  assign ex_w       = valid_p1 && wen_p1;
  assign unused_fwd = ^{bus.exm_wd, bus.mwb_wd};

  assign v1_p0 = rf_sel(rs_a_p0, bus.rs_data);
  assign v2_p0 = rf_sel(rt_a_p0, bus.rt_data);

  assign hazard_p0 = bus.in_valid &&
    ((use_rs_p0 && pending(rs_a_p0, ex_w, wa_p1, bus.exm_wen, bus.exm_wa, bus.mwb_wen, bus.mwb_wa)) ||
     (use_rt_p0 && pending(rt_a_p0, ex_w, wa_p1, bus.exm_wen, bus.exm_wa, bus.mwb_wen, bus.mwb_wa)));
`endif

  assign bus.stall_out = reset_n && !bus.flush && hazard_p0;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_p1 <= 1'b0;
      v1_p1    <= 32'd0;
      v2_p1    <= 32'd0;
      imm_p1   <= 16'd0;
      opt_p1   <= 4'd0;
      wen_p1   <= 1'b0;
      wa_p1    <= 5'd0;
      memrd_p1 <= 1'b0;
      memwr_p1 <= 1'b0;
      pc_p1    <= 32'd0;
    end else begin
      v1_p1  <= v1_p0;
      v2_p1  <= v2_p0;
      imm_p1 <= bus.in_instr[15:0];
      opt_p1 <= opt_p0;
      wa_p1  <= wa_p0;
      pc_p1  <= bus.in_pc;
      if (bus.flush || hazard_p0 || !bus.in_valid) begin
        valid_p1 <= 1'b0;
        wen_p1   <= 1'b0;
        memrd_p1 <= 1'b0;
        memwr_p1 <= 1'b0;
      end else begin
        valid_p1 <= 1'b1;
        wen_p1   <= wen_p0;
        memrd_p1 <= memrd_p0;
        memwr_p1 <= memwr_p0;
      end
    end
  end

  assign bus.out_valid = valid_p1;
  assign bus.v1        = v1_p1;
  assign bus.v2        = v2_p1;
  assign bus.imm16     = imm_p1;
  assign bus.opt       = opt_p1;
  assign bus.out_wen   = wen_p1;
  assign bus.out_wa    = wa_p1;
  assign bus.out_memrd = memrd_p1;
  assign bus.out_memwr = memwr_p1;
  assign bus.out_pc    = pc_p1;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed literal checks plus randomized traffic against a
// cycle-level behavioural model; follows ALU_ISSUE_FORWARD_EN like the design.
module tb_alu_issue;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_if bus();
  alu_issue dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] v1, v2;
    logic [15:0] imm;
    logic [3:0]  opt;
    logic        wen;
    logic [4:0]  wa;
    logic        memrd, memwr;
    logic [31:0] pc;
  } st_t;

  st_t exp_st;
  bit  armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    return w;
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  // kind: 0 addu, 1 subu, 2 andi, 3 ori, 4 lw, 5 sw, 6 lui, 7 anything else
  function automatic int kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:   return (ins[5:0] == 6'h21) ? 0 : (ins[5:0] == 6'h23) ? 1 : 7;
      6'h0c:   return 2;
      6'h0d:   return 3;
      6'h23:   return 4;
      6'h2b:   return 5;
      6'h0f:   return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [3:0] m_opt(input int k);
    int t[8] = '{0, 1, 2, 3, 4, 4, 5, 0};
    return 4'(t[k]);
  endfunction

  function automatic logic [4:0] m_dest(input int k, input logic [31:0] ins);
    if (k <= 1) return ins[15:11];
    if (k == 2 || k == 3 || k == 4 || k == 6) return ins[20:16];
    return 5'd0;
  endfunction

  function automatic bit m_uses_rs(input int k); return k <= 5; endfunction
  function automatic bit m_uses_rt(input int k); return k == 0 || k == 1 || k == 5; endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 0;
`ifdef ALU_ISSUE_FORWARD_EN
    if (bus.exm_wen && bus.exm_wa == a) return bus.exm_wd;
    if (bus.mwb_wen && bus.mwb_wa == a) return bus.mwb_wd;
`endif
    return rf;
  endfunction

  function automatic bit m_hazard();
    int k;
    bit ur, ut;
    logic [4:0] rs, rt;
    k  = kind_of(bus.in_instr);
    ur = m_uses_rs(k);
    ut = m_uses_rt(k);
    rs = bus.in_instr[25:21];
    rt = bus.in_instr[20:16];
    if (!bus.in_valid) return 0;
`ifdef ALU_ISSUE_FORWARD_EN
    if (!(exp_st.valid && exp_st.memrd && exp_st.wa != 0)) return 0;
    return (ur && rs == exp_st.wa) || (ut && rt == exp_st.wa);
`else
    for (int s = 0; s < 2; s++) begin
      logic [4:0] a;
      bit used;
      a    = (s == 0) ? rs : rt;
      used = (s == 0) ? ur : ut;
      if (used && a != 0) begin
        if (exp_st.valid && exp_st.wen && exp_st.wa == a) return 1;
        if (bus.exm_wen && bus.exm_wa == a) return 1;
        if (bus.mwb_wen && bus.mwb_wa == a) return 1;
      end
    end
    return 0;
`endif
  endfunction

  function automatic st_t m_next();
    st_t n;
    int k;
    n = '{default: '0};
    if (!reset_n) return n;
    k       = kind_of(bus.in_instr);
    n.v1    = m_operand(bus.in_instr[25:21], bus.rs_data);
    n.v2    = m_operand(bus.in_instr[20:16], bus.rt_data);
    n.imm   = bus.in_instr[15:0];
    n.opt   = m_opt(k);
    n.wa    = m_dest(k, bus.in_instr);
    n.pc    = bus.in_pc;
    if (bus.flush || m_hazard() || !bus.in_valid) return n;
    n.valid = 1;
    n.wen   = (n.wa != 0) && (k <= 4 || k == 6);
    n.memrd = (k == 4);
    n.memwr = (k == 5);
    return n;
  endfunction

  // One compare process: at each falling edge check outputs, then advance the model.
  always begin
    @(negedge clk);
    if (armed) begin
      check("m_valid", 32'(bus.out_valid), 32'(exp_st.valid));
      check("m_wen",   32'(bus.out_wen),   32'(exp_st.wen));
      check("m_memrd", 32'(bus.out_memrd), 32'(exp_st.memrd));
      check("m_memwr", 32'(bus.out_memwr), 32'(exp_st.memwr));
      check("m_stall", 32'(bus.stall_out), 32'(reset_n && !bus.flush && m_hazard()));
      if (exp_st.valid) begin
        check("m_v1",  bus.v1,            exp_st.v1);
        check("m_v2",  bus.v2,            exp_st.v2);
        check("m_imm", 32'(bus.imm16),    32'(exp_st.imm));
        check("m_opt", 32'(bus.opt),      32'(exp_st.opt));
        check("m_wa",  32'(bus.out_wa),   32'(exp_st.wa));
        check("m_pc",  bus.out_pc,        exp_st.pc);
      end
    end
    exp_st = m_next();
    if (!reset_n) armed = 1;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0;
    bus.in_instr = 0;
    bus.in_pc    = 0;
    bus.rs_data  = 0;
    bus.rt_data  = 0;
    bus.exm_wen  = 0;
    bus.exm_wa   = 0;
    bus.exm_wd   = 0;
    bus.mwb_wen  = 0;
    bus.mwb_wa   = 0;
    bus.mwb_wd   = 0;
    bus.flush    = 0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_wen"},   32'(bus.out_wen),   0);
    check({tag, "_memwr"}, 32'(bus.out_memwr), 0);
    check({tag, "_memrd"}, 32'(bus.out_memrd), 0);
    check({tag, "_v1"},    bus.v1,             0);
    check({tag, "_v2"},    bus.v2,             0);
    check({tag, "_imm"},   32'(bus.imm16),     0);
    check({tag, "_opt"},   32'(bus.opt),       0);
    check({tag, "_wa"},    32'(bus.out_wa),    0);
    check({tag, "_pc"},    bus.out_pc,         0);
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd;
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    rd = $urandom_range(0, 7);
    case ($urandom_range(0, 8))
      0: return r_type(rs, rt, rd, 'h21);
      1: return r_type(rs, rt, rd, 'h23);
      2: return i_type('h0c, rs, rt, $urandom);
      3: return i_type('h0d, rs, rt, $urandom);
      4: return i_type('h23, rs, rt, $urandom);
      5: return i_type('h2b, rs, rt, $urandom);
      6: return i_type('h0f, rs, rt, $urandom);
      7: return r_type(rs, rt, rd, 'h20);
      default: return i_type('h08, rs, rt, $urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset_n = 0;
    issue(i_type('h2b, 1, 2, 8), 32'h40);
    bus.rs_data = 32'h77;
    #1;
    check("rst_stall", 32'(bus.stall_out), 0);
    tick();
    tick();
    chk_zero("rst");

    // ori $1,$0,0x1234
    reset_n = 1;
    idle();
    issue(i_type('h0d, 0, 1, 'h1234), 32'h100);
    bus.rs_data = 32'h55;
    tick();
    check("ori_opt",   32'(bus.opt),       3);
    check("ori_v1",    bus.v1,             0);
    check("ori_imm",   32'(bus.imm16),     32'h1234);
    check("ori_wa",    32'(bus.out_wa),    1);
    check("ori_wen",   32'(bus.out_wen),   1);
    check("ori_valid", 32'(bus.out_valid), 1);
    check("ori_pc",    bus.out_pc,         32'h100);
    idle();
    tick();

    // addu $3,$1,$2 with pending writes to $1 and $2
    issue(r_type(1, 2, 3, 'h21), 32'h104);
    bus.rs_data = 99;
    bus.rt_data = 99;
    bus.exm_wen = 1; bus.exm_wa = 1; bus.exm_wd = 5;
    bus.mwb_wen = 1; bus.mwb_wa = 2; bus.mwb_wd = 7;
    #1;
`ifdef ALU_ISSUE_FORWARD_EN
    check("addu_stall", 32'(bus.stall_out), 0);
    tick();
    check("addu_v1",  bus.v1,          5);
    check("addu_v2",  bus.v2,          7);
    check("addu_opt", 32'(bus.opt),    0);
    check("addu_wa",  32'(bus.out_wa), 3);
`else
    check("nf_stall_exm", 32'(bus.stall_out), 1);
    tick();
    check("nf_bubble1", 32'(bus.out_valid), 0);
    bus.exm_wen = 0;
    bus.mwb_wa  = 1;
    #1;
    check("nf_stall_mwb", 32'(bus.stall_out), 1);
    tick();
    check("nf_bubble2", 32'(bus.out_valid), 0);
    bus.mwb_wen = 0;
    #1;
    check("nf_stall_clr", 32'(bus.stall_out), 0);
    tick();
    check("nf_addu_valid", 32'(bus.out_valid), 1);
    check("nf_addu_v1",    bus.v1,             99);
    check("nf_addu_wa",    32'(bus.out_wa),    3);
`endif
    idle();
    tick();

    // lw $4,8($1) followed by subu $5,$4,$6
    issue(i_type('h23, 1, 4, 8), 32'h200);
    bus.rs_data = 32'h1000;
    tick();
    check("lw_memrd", 32'(bus.out_memrd), 1);
    check("lw_opt",   32'(bus.opt),       4);
    check("lw_wa",    32'(bus.out_wa),    4);
    check("lw_v1",    bus.v1,             32'h1000);
    issue(r_type(4, 6, 5, 'h23), 32'h204);
    bus.rs_data = 32'h1111;
    bus.rt_data = 32'h3;
    #1;
    check("lu_stall", 32'(bus.stall_out), 1);
    tick();
    check("lu_bubble_valid", 32'(bus.out_valid), 0);
    check("lu_bubble_wen",   32'(bus.out_wen),   0);
    bus.mwb_wen = 1; bus.mwb_wa = 4; bus.mwb_wd = 32'hABCD;
`ifdef ALU_ISSUE_FORWARD_EN
    #1;
    check("lu_stall_done", 32'(bus.stall_out), 0);
`else
    #1;
    check("nf_lu_stall_mwb", 32'(bus.stall_out), 1);
    tick();
    bus.mwb_wen = 0;
    bus.rs_data = 32'hABCD;
`endif
    tick();
    check("subu_valid", 32'(bus.out_valid), 1);
    check("subu_v1",    bus.v1,             32'hABCD);
    check("subu_opt",   32'(bus.opt),       1);
    check("subu_wa",    32'(bus.out_wa),    5);
    idle();
    tick();

    // load-use condition together with flush
    issue(i_type('h23, 1, 4, 8), 32'h300);
    tick();
    issue(r_type(4, 6, 5, 'h23), 32'h304);
    bus.flush = 1;
    #1;
    check("flush_stall", 32'(bus.stall_out), 0);
    tick();
    check("flush_valid", 32'(bus.out_valid), 0);
    check("flush_wen",   32'(bus.out_wen),   0);
    idle();
    tick();

    // reset mid-stream while a sw is presented
    issue(i_type('h2b, 3, 2, 'h10), 32'h400);
    bus.rs_data = 32'h12; bus.rt_data = 32'h34;
    reset_n = 0;
    #1;
    check("rst2_stall", 32'(bus.stall_out), 0);
    tick();
    chk_zero("rst2");
    reset_n = 1;

    // addu $0,$1,$1 must not write
    idle();
    issue(r_type(1, 1, 0, 'h21), 32'h500);
    bus.rs_data = 8; bus.rt_data = 8;
    tick();
    check("r0_valid", 32'(bus.out_valid), 1);
    check("r0_wen",   32'(bus.out_wen),   0);
    check("r0_v1",    bus.v1,             8);

    // lui and an undecoded opcode
    idle();
    issue(i_type('h0f, 3, 7, 'hBEEF), 32'h504);
    tick();
    check("lui_opt", 32'(bus.opt),     5);
    check("lui_wa",  32'(bus.out_wa),  7);
    check("lui_wen", 32'(bus.out_wen), 1);
    idle();
    tick();
    issue(i_type('h3f, 2, 9, 'h1), 32'h508);
    tick();
    check("junk_valid", 32'(bus.out_valid), 1);
    check("junk_opt",   32'(bus.opt),       0);
    check("junk_wen",   32'(bus.out_wen),   0);
    check("junk_mem",   32'({bus.out_memrd, bus.out_memwr}), 0);

    // randomized traffic with dense register collisions
    for (int i = 0; i < 800; i++) begin
      reset_n      = ($urandom_range(0, 59) != 0);
      bus.in_valid = ($urandom_range(0, 9) != 0);
      bus.in_instr = rand_instr();
      bus.in_pc    = $urandom;
      bus.rs_data  = $urandom;
      bus.rt_data  = $urandom;
      bus.exm_wen  = $urandom_range(0, 1);
      bus.exm_wa   = 5'($urandom_range(0, 7));
      bus.exm_wd   = $urandom;
      bus.mwb_wen  = $urandom_range(0, 1);
      bus.mwb_wa   = 5'($urandom_range(0, 7));
      bus.mwb_wd   = $urandom;
      bus.flush    = ($urandom_range(0, 9) == 0);
      tick();
    end

    reset_n = 1;
    idle();
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
